// File: rtl/regfile_8x16_pkg.sv
// Shared register-file constants, imported by the CPU decoder and the datapath.
// mux2_16 is the datapath's 16-bit 2:1 mux block, used for all read and forward selection.
package regfile_8x16_pkg;

  localparam int REG_WIDTH = 16;
  localparam int REG_AW    = 3;
  localparam int REG_COUNT = 8;
  localparam logic [REG_WIDTH-1:0] REG_ZERO = 16'h0000;

  function automatic logic [REG_WIDTH-1:0] mux2_16(
    input logic                 sel,
    input logic [REG_WIDTH-1:0] in0,
    input logic [REG_WIDTH-1:0] in1
  );
    return sel ? in1 : in0;
  endfunction

endpackage

// File: rtl/regfile_8x16_reg16_en.sv
// reg16_en: 16-bit register with synchronous load enable and asynchronous active-high clear.
module reg16_en
  import regfile_8x16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [REG_WIDTH-1:0] i_d,
  output logic [REG_WIDTH-1:0] o_q
);

  logic [REG_WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= REG_ZERO;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_8x16.sv
// regfile_8x16: eight 16-bit registers (r0 hardwired to zero), two combinational reads, one clocked write.
// Define REGFILE_BYPASS_EN to forward wdata to a read port addressing the register being written.
module regfile_8x16
  import regfile_8x16_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int AW    = REG_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [REG_COUNT-1:1]            w_writeEn;
  logic [REG_COUNT-1:0][WIDTH-1:0] w_regs;
  logic [WIDTH-1:0]                w_treeA;
  logic [WIDTH-1:0]                w_treeB;

  // One-hot write decode; r0 has no enable line so writes to address 0 vanish.
  always_comb begin
    w_writeEn = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      w_writeEn[i] = we && (waddr == AW'(i));
    end
  end

  assign w_regs[0] = REG_ZERO;

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
    reg16_en u_reg (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_writeEn[i]),
      .i_d  (wdata),
      .o_q  (w_regs[i])
    );
  end

  // Three levels of 2:1 muxes, LSB of the address selecting at the first level.
  function automatic logic [WIDTH-1:0] readTree(
    input logic [AW-1:0]                   addr,
    input logic [REG_COUNT-1:0][WIDTH-1:0] regs
  );
    logic [3:0][WIDTH-1:0] l1;
    logic [1:0][WIDTH-1:0] l2;
    for (int i = 0; i < 4; i++) begin
      l1[i] = mux2_16(addr[0], regs[2*i], regs[2*i+1]);
    end
    for (int j = 0; j < 2; j++) begin
      l2[j] = mux2_16(addr[1], l1[2*j], l1[2*j+1]);
    end
    return mux2_16(addr[2], l2[0], l2[1]);
  endfunction

  assign w_treeA = readTree(raddr_a, w_regs);
  assign w_treeB = readTree(raddr_b, w_regs);

`ifdef REGFILE_BYPASS_EN
  logic w_fwdA;
  logic w_fwdB;

  // Forwarding is suppressed during reset so the ports keep reading zero.
  assign w_fwdA  = we && !rst && (waddr != '0) && (raddr_a == waddr);
  assign w_fwdB  = we && !rst && (waddr != '0) && (raddr_b == waddr);
  assign rdata_a = mux2_16(w_fwdA, w_treeA, wdata);
  assign rdata_b = mux2_16(w_fwdB, w_treeB, wdata);
`else
  assign rdata_a = w_treeA;
  assign rdata_b = w_treeB;
`endif

endmodule
